pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard controller for the five-stage pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It keeps its own scoreboard of in-flight destination registers, and from it generates load-use stalls, branch flushes, forwarding selects and a global freeze while a memory access is outstanding. It sits beside the ID stage and drives the write-enable and flush inputs of every pipeline register.

## Interface
Parameters:
- WAIT_MAX, 255: memory-wait cycles before MemTimeout asserts.
- CNT_W, 16: width of the StallCount performance counter.

Ports:
- CLOCK  in  1  sole clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- ID_Valid  in  1  ID stage holds a real instruction.
- ID_RSAddr / ID_RTAddr  in  5  source registers of the ID instruction.
- ID_UsesRT  in  1  ID instruction reads rt.
- ID_RegWriteEN, ID_Mem2RegSEL  in  1  control bits of the ID instruction.
- ID_DstAddr  in  5  destination register of the ID instruction, after the RegDst mux.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- MEM_MemReq  in  1  MEM stage is performing a load or store.
- MemReady  in  1  data memory completes the request this cycle.
- PCWriteEN, IFIDWriteEN  out  1  hold PC and IF/ID when low.
- PipeEN  out  1  enable for ID/EX, EX/MEM and MEM/WB; low means freeze.
- IFIDFlush, IDEXFlush  out  1  load a bubble into the register.
- FwdA, FwdB  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- StallCount  out  CNT_W  saturating count of stall and freeze cycles.
- MemTimeout  out  1  sticky error flag.

## Operation
- Scoreboard has three slots: EX, MEM and WB. Each slot holds {valid, regwrite, mem2reg, dst[4:0], rs[4:0], rt[4:0]}.
- Slot advance occurs when PipeEN=1: WB<=MEM, MEM<=EX, EX<=ID fields.
  - EX loads a bubble (valid=0) instead when a stall or flush occurs, or when ID_Valid=0.
  - All slots hold when PipeEN=0.
- A slot "matches" register r when valid & regwrite & dst!=0 & dst==r.
- Load-use stall: EX slot has mem2reg=1 and matches ID_RSAddr, or matches ID_RTAddr with ID_UsesRT=1, and ID_Valid=1.
  - Outputs: PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1. The stall lasts exactly one cycle.
- Branch flush: EX_BranchTaken=1 gives IFIDFlush=1, IDEXFlush=1 and PCWriteEN=1 (PC loads the target).
  - Branch flush overrides a simultaneous load-use stall, because the stalled instruction is wrong-path.
- Forwarding for the EX instruction's rs (FwdA) and rt (FwdB):
  - 01 if the MEM slot matches and has mem2reg=0.
  - Otherwise 10 if the WB slot matches.
  - Otherwise 00. MEM takes priority over WB.
- FSM has two states, RUN and MEM_WAIT.
  - RUN: MEM_MemReq & !MemReady goes to MEM_WAIT and sets PipeEN=PCWriteEN=IFIDWriteEN=0. Waitcnt is cleared.
  - MEM_WAIT: the freeze holds while MemReady=0, and waitcnt increments, saturating at WAIT_MAX.
  - MEM_WAIT: the cycle MemReady=1, PipeEN=1 (normal advance) and the FSM returns to RUN.
  - A request with MemReady=1 in the same cycle never leaves RUN.
- Freeze takes priority over everything: flushes are forced to 0 while frozen. EX_BranchTaken is re-evaluated on the release cycle.
- MemTimeout is set when waitcnt reaches WAIT_MAX. It is cleared only by RESET.
- StallCount increments in every cycle with a load-use stall or a freeze. It saturates at all-ones. It does not count a branch flush.

## Timing
- All control outputs are combinational from registered state plus the current ID/EX/MEM inputs. They are valid before the same posedge.
- Stall, flush and forward decisions have zero-cycle latency. Scoreboard and counter updates take effect at the next posedge.
- On RESET, and immediately asynchronously:
  - All slots are invalid, the state is RUN and waitcnt=0.
  - Outputs: PCWriteEN=1, IFIDWriteEN=1, PipeEN=1, IFIDFlush=0, IDEXFlush=0, FwdA=FwdB=00, StallCount=0, MemTimeout=0.
- RESET asserted during MEM_WAIT aborts the wait. It does not set the timeout flag.

## Structure
- Package pipe_ctrl_pkg holds:
  - FWD_REG, FWD_MEM and FWD_WB constants.
  - The RUN/MEM_WAIT state encoding.
  - The sb_slot_t struct and the REG_ZERO constant.
- Sub-module sat_counter (parameterised width, async active-high reset, inc input) is instantiated for StallCount and for waitcnt.

## Test plan
- lw $2 followed by add $3,$2,$4 -> one cycle with PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1. Next cycle FwdA=10. StallCount=1.
- add $2 followed by sub $5,$2,$2 -> no stall; FwdA=FwdB=01 when sub is in EX.
- Write to $0 followed by a reader of $0 -> no stall, FwdA=00.
- EX_BranchTaken=1 coincident with a load-use condition -> IFIDFlush=IDEXFlush=1 and PCWriteEN=1. StallCount unchanged.
- MEM_MemReq=1 with MemReady low for 3 cycles -> PipeEN=0 for 3 cycles. Advance on the MemReady cycle. StallCount=3, and all slots are held.
- WAIT_MAX=4, MemReady held low -> MemTimeout rises after 4 wait cycles. It stays high after release until RESET pulses, which also clears StallCount mid-wait.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
//==========================================================================
// pipe_ctrl_pkg: shared types, encodings and helpers for the hazard controller
// Rev 1.0
//==========================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       mem2reg;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
    } sb_slot_t;

    localparam sb_slot_t SLOT_BUBBLE = '0;

    function automatic logic slot_match(input sb_slot_t s, input logic [4:0] r);
        return s.valid & s.regwrite & (s.dst != REG_ZERO) & (s.dst == r);
    endfunction

    // A load in MEM has no data yet, so it cannot be a forwarding source.
    function automatic logic [1:0] fwd_select(input sb_slot_t mem, input sb_slot_t wb,
                                              input logic [4:0] r);
        logic [1:0] sel;
        sel = FWD_REG;
        if (slot_match(mem, r) && !mem.mem2reg) begin
            sel = FWD_MEM;
        end else if (slot_match(wb, r)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//==========================================================================
// sat_counter: up-counter with synchronous clear that sticks at MAX
// Rev 1.0
//==========================================================================
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != MAX)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//==========================================================================
// pipe_hazard_ctrl: scoreboard-based stall/flush/forward/freeze control
// Rev 1.0
//==========================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_RSAddr,
    input  logic [4:0]       ID_RTAddr,
    input  logic             ID_UsesRT,
    input  logic             ID_RegWriteEN,
    input  logic             ID_Mem2RegSEL,
    input  logic [4:0]       ID_DstAddr,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemReq,
    input  logic             MemReady,
    output logic             PCWriteEN,
    output logic             IFIDWriteEN,
    output logic             PipeEN,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] StallCount,
    output logic             MemTimeout
);

    localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    sb_slot_t    ex_q, mem_q, wb_q, ex_d;
    logic [0:0]  state_q, state_d;
    logic        timeout_q;

    logic        w_freeze;
    logic        w_wait_clr;
    logic        w_wait_inc;
    logic        w_load_use;
    logic        w_stall_inc;
    logic        w_at_max;
    logic [WAIT_W-1:0] w_waitcnt;
    logic        w_unused;

    always_comb begin
        state_d    = state_q;
        w_freeze   = 1'b0;
        w_wait_clr = 1'b0;
        w_wait_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (MEM_MemReq && !MemReady) begin
                    w_freeze   = 1'b1;
                    w_wait_clr = 1'b1;
                    state_d    = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (MemReady) begin
                    state_d = ST_RUN;
                end else begin
                    w_freeze   = 1'b1;
                    w_wait_inc = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign w_load_use = ID_Valid & ex_q.mem2reg &
                        (slot_match(ex_q, ID_RSAddr) | (ID_UsesRT & slot_match(ex_q, ID_RTAddr)));

    // Freeze masks everything; a taken branch wins over a load-use on the wrong path.
    assign PipeEN      = ~w_freeze;
    assign PCWriteEN   = ~w_freeze & (EX_BranchTaken | ~w_load_use);
    assign IFIDWriteEN = ~w_freeze & (EX_BranchTaken | ~w_load_use);
    assign IFIDFlush   = ~w_freeze & EX_BranchTaken;
    assign IDEXFlush   = ~w_freeze & (EX_BranchTaken | w_load_use);

    assign FwdA = fwd_select(mem_q, wb_q, ex_q.rs);
    assign FwdB = fwd_select(mem_q, wb_q, ex_q.rt);

    assign w_stall_inc = w_freeze | (w_load_use & ~EX_BranchTaken);

    always_comb begin
        ex_d = SLOT_BUBBLE;
        if (ID_Valid && !IDEXFlush) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = ID_RegWriteEN;
            ex_d.mem2reg  = ID_Mem2RegSEL;
            ex_d.dst      = ID_DstAddr;
            ex_d.rs       = ID_RSAddr;
            ex_d.rt       = ID_RTAddr;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ex_q      <= SLOT_BUBBLE;
            mem_q     <= SLOT_BUBBLE;
            wb_q      <= SLOT_BUBBLE;
            state_q   <= ST_RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_q | w_at_max;
            if (!w_freeze) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
        end
    end

    sat_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_W'(WAIT_MAX))
    ) u_waitcnt (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .clr_i   (w_wait_clr),
        .inc_i   (w_wait_inc),
        .count_o (w_waitcnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_stallcnt (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .clr_i   (1'b0),
        .inc_i   (w_stall_inc),
        .count_o (StallCount)
    );

    // The counter parks at WAIT_MAX, so the flag is visible the cycle it gets there.
    assign w_at_max   = (w_waitcnt == WAIT_W'(WAIT_MAX));
    assign MemTimeout = timeout_q | w_at_max;

    assign w_unused = ^{wb_q.mem2reg, wb_q.rs, wb_q.rt, mem_q.rs, mem_q.rt};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
//==========================================================================
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic vs a reference model
// Rev 1.0
//==========================================================================
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic             CLOCK = 1'b0;
    logic             RESET;
    logic             ID_Valid, ID_UsesRT, ID_RegWriteEN, ID_Mem2RegSEL;
    logic [4:0]       ID_RSAddr, ID_RTAddr, ID_DstAddr;
    logic             EX_BranchTaken, MEM_MemReq, MemReady;
    logic             PCWriteEN, IFIDWriteEN, PipeEN, IFIDFlush, IDEXFlush, MemTimeout;
    logic [1:0]       FwdA, FwdB;
    logic [CNT_W-1:0] StallCount;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ID_Valid(ID_Valid), .ID_RSAddr(ID_RSAddr), .ID_RTAddr(ID_RTAddr),
        .ID_UsesRT(ID_UsesRT), .ID_RegWriteEN(ID_RegWriteEN), .ID_Mem2RegSEL(ID_Mem2RegSEL),
        .ID_DstAddr(ID_DstAddr), .EX_BranchTaken(EX_BranchTaken),
        .MEM_MemReq(MEM_MemReq), .MemReady(MemReady),
        .PCWriteEN(PCWriteEN), .IFIDWriteEN(IFIDWriteEN), .PipeEN(PipeEN),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .FwdA(FwdA), .FwdB(FwdB),
        .StallCount(StallCount), .MemTimeout(MemTimeout)
    );

    logic [9+CNT_W:0] obs;
    assign obs = {PCWriteEN, IFIDWriteEN, PipeEN, IFIDFlush, IDEXFlush, FwdA, FwdB, StallCount, MemTimeout};

    // Reference model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        bit       v;
        bit       rw;
        bit       m2r;
        bit [4:0] dst;
        bit [4:0] rs;
        bit [4:0] rt;
    } mslot_t;

    mslot_t m_pipe [3];
    bit     m_waiting;
    int     m_wcnt;
    bit     m_tout;
    int     m_scnt;

    function automatic bit writes(input mslot_t s, input bit [4:0] r);
        return s.v && s.rw && (r != 0) && (s.dst == r);
    endfunction

    function automatic bit [1:0] src_of(input mslot_t mem, input mslot_t wb, input bit [4:0] r);
        if (writes(mem, r) && !mem.m2r) return 2'd1;
        if (writes(wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    logic e_frz, e_lu, e_pc, e_ifid, e_iff, e_idf;
    logic [1:0] e_fa, e_fb;
    logic [9+CNT_W:0] exp_vec;

    always_comb begin
        e_frz  = m_waiting ? !MemReady : (MEM_MemReq && !MemReady);
        e_lu   = ID_Valid && m_pipe[0].m2r &&
                 (writes(m_pipe[0], ID_RSAddr) || (ID_UsesRT && writes(m_pipe[0], ID_RTAddr)));
        e_pc   = 1'b1;
        e_ifid = 1'b1;
        e_iff  = 1'b0;
        e_idf  = 1'b0;
        if (e_frz) begin
            e_pc   = 1'b0;
            e_ifid = 1'b0;
        end else if (EX_BranchTaken) begin
            e_iff = 1'b1;
            e_idf = 1'b1;
        end else if (e_lu) begin
            e_pc   = 1'b0;
            e_ifid = 1'b0;
            e_idf  = 1'b1;
        end
        e_fa    = src_of(m_pipe[1], m_pipe[2], m_pipe[0].rs);
        e_fb    = src_of(m_pipe[1], m_pipe[2], m_pipe[0].rt);
        exp_vec = {e_pc, e_ifid, !e_frz, e_iff, e_idf, e_fa, e_fb, CNT_W'(m_scnt), m_tout};
    end

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < 3; k++) m_pipe[k] <= '0;
            m_waiting <= 1'b0;
            m_wcnt    <= 0;
            m_tout    <= 1'b0;
            m_scnt    <= 0;
        end else begin
            if (!e_frz) begin
                m_pipe[2] <= m_pipe[1];
                m_pipe[1] <= m_pipe[0];
                m_pipe[0] <= (e_idf || !ID_Valid) ? '0 :
                             {1'b1, ID_RegWriteEN, ID_Mem2RegSEL, ID_DstAddr, ID_RSAddr, ID_RTAddr};
            end
            if (!m_waiting) begin
                if (MEM_MemReq && !MemReady) begin
                    m_waiting <= 1'b1;
                    m_wcnt    <= 0;
                end
            end else if (MemReady) begin
                m_waiting <= 1'b0;
            end else begin
                if (m_wcnt < WAIT_MAX) m_wcnt <= m_wcnt + 1;
                if (m_wcnt + 1 >= WAIT_MAX) m_tout <= 1'b1;
            end
            if ((e_frz || (e_lu && !EX_BranchTaken)) && (m_scnt < CNT_SAT)) m_scnt <= m_scnt + 1;
        end
    end

    task automatic idle();
        ID_Valid = 0; ID_RSAddr = 0; ID_RTAddr = 0; ID_UsesRT = 0;
        ID_RegWriteEN = 0; ID_Mem2RegSEL = 0; ID_DstAddr = 0;
        EX_BranchTaken = 0; MEM_MemReq = 0; MemReady = 0;
    endtask

    task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit uses_rt,
                          input bit rw, input bit m2r, input bit [4:0] dst);
        ID_Valid = 1; ID_RSAddr = rs; ID_RTAddr = rt; ID_UsesRT = uses_rt;
        ID_RegWriteEN = rw; ID_Mem2RegSEL = m2r; ID_DstAddr = dst;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 0;
    endtask

    task automatic test_reset();
        idle();
        RESET = 0;
        #2 RESET = 1;
        #1;
        if (obs !== {5'b11100, 4'b0000, {CNT_W{1'b0}}, 1'b0}) begin
            $display("FAIL reset_async: got %b want %b", obs, {5'b11100, 4'b0000, {CNT_W{1'b0}}, 1'b0});
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        @(negedge CLOCK);
        #1;
        if (obs !== {5'b11100, 4'b0000, {CNT_W{1'b0}}, 1'b0}) begin
            $display("FAIL reset_held: got %b want %b", obs, {5'b11100, 4'b0000, {CNT_W{1'b0}}, 1'b0});
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        RESET = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd1, 5'd0, 0, 1, 1, 5'd2);            // lw $2
        @(negedge CLOCK);
        set_id(5'd2, 5'd4, 1, 1, 0, 5'd3);            // add $3,$2,$4
        #1;
        if ({PCWriteEN, IFIDWriteEN, IDEXFlush, IFIDFlush} !== 4'b0010) begin
            $display("FAIL lu_stall: PC,IFID,IDEXFl,IFIDFl got %b want 0010",
                     {PCWriteEN, IFIDWriteEN, IDEXFlush, IFIDFlush});
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        #1;
        if ({PCWriteEN, IFIDWriteEN, IDEXFlush} !== 3'b110 || StallCount !== CNT_W'(1)) begin
            $display("FAIL lu_one_cycle: PC,IFID,IDEXFl got %b want 110, StallCount got %0d want 1",
                     {PCWriteEN, IFIDWriteEN, IDEXFlush}, StallCount);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        idle();
        #1;
        if (FwdA !== 2'b10 || FwdB !== 2'b00) begin
            $display("FAIL lu_fwd_wb: FwdA=%b FwdB=%b want 10 00", FwdA, FwdB);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
    endtask

    task automatic test_forward_mem();
        do_reset();
        set_id(5'd1, 5'd3, 1, 1, 0, 5'd2);            // add $2,$1,$3
        @(negedge CLOCK);
        set_id(5'd2, 5'd2, 1, 1, 0, 5'd5);            // sub $5,$2,$2
        #1;
        if (PCWriteEN !== 1'b1 || IDEXFlush !== 1'b0) begin
            $display("FAIL alu_no_stall: PCWriteEN=%b IDEXFlush=%b want 1 0", PCWriteEN, IDEXFlush);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        idle();
        #1;
        if (FwdA !== 2'b01 || FwdB !== 2'b01) begin
            $display("FAIL fwd_mem: FwdA=%b FwdB=%b want 01 01", FwdA, FwdB);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(5'd1, 5'd0, 0, 1, 1, 5'd0);            // lw $0
        @(negedge CLOCK);
        set_id(5'd0, 5'd0, 1, 1, 0, 5'd7);            // reader of $0
        #1;
        if (PCWriteEN !== 1'b1 || IDEXFlush !== 1'b0) begin
            $display("FAIL zero_no_stall: PCWriteEN=%b IDEXFlush=%b want 1 0", PCWriteEN, IDEXFlush);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        idle();
        #1;
        if (FwdA !== 2'b00 || FwdB !== 2'b00) begin
            $display("FAIL zero_fwd: FwdA=%b FwdB=%b want 00 00", FwdA, FwdB);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
    endtask

    task automatic test_branch_override();
        do_reset();
        set_id(5'd1, 5'd0, 0, 1, 1, 5'd2);            // lw $2
        @(negedge CLOCK);
        set_id(5'd2, 5'd4, 1, 1, 0, 5'd3);            // dependent add, wrong path
        EX_BranchTaken = 1;
        #1;
        if ({IFIDFlush, IDEXFlush, PCWriteEN, PipeEN} !== 4'b1111) begin
            $display("FAIL branch_over_lu: IFIDFl,IDEXFl,PC,Pipe got %b want 1111",
                     {IFIDFlush, IDEXFlush, PCWriteEN, PipeEN});
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        EX_BranchTaken = 0;
        #1;
        if (StallCount !== '0 || PCWriteEN !== 1'b1) begin
            $display("FAIL branch_no_count: StallCount=%0d PCWriteEN=%b want 0 1", StallCount, PCWriteEN);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_id(5'd1, 5'd3, 1, 1, 0, 5'd2);
        @(negedge CLOCK);
        set_id(5'd2, 5'd2, 1, 1, 0, 5'd5);
        @(negedge CLOCK);
        idle();
        MEM_MemReq = 1;
        EX_BranchTaken = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if ({PipeEN, PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXFlush} !== 5'b00000 || FwdA !== 2'b01) begin
                $display("FAIL freeze_c%0d: Pipe,PC,IFID,IFIDFl,IDEXFl got %b want 00000, FwdA=%b want 01",
                         c, {PipeEN, PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXFlush}, FwdA);
                errors++;
            end
            checks++;
            @(negedge CLOCK);
        end
        MemReady = 1;
        #1;
        if ({PipeEN, IFIDFlush, IDEXFlush} !== 3'b111 || FwdA !== 2'b01 || StallCount !== CNT_W'(3)) begin
            $display("FAIL release: Pipe,IFIDFl,IDEXFl got %b want 111, FwdA=%b want 01, StallCount=%0d want 3",
                     {PipeEN, IFIDFlush, IDEXFlush}, FwdA, StallCount);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        idle();
        #1;
        if (StallCount !== CNT_W'(3) || PipeEN !== 1'b1 || FwdA !== 2'b00) begin
            $display("FAIL after_release: StallCount=%0d PipeEN=%b FwdA=%b want 3 1 00", StallCount, PipeEN, FwdA);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
    endtask

    task automatic test_timeout();
        do_reset();
        MEM_MemReq = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (MemTimeout !== (c >= 5)) begin
                $display("FAIL timeout_c%0d: MemTimeout=%b want %b", c, MemTimeout, (c >= 5));
                errors++;
            end
            checks++;
            @(negedge CLOCK);
        end
        repeat (14) @(negedge CLOCK);
        #1;
        if (StallCount !== CNT_W'(CNT_SAT) || PipeEN !== 1'b0) begin
            $display("FAIL stall_sat: StallCount=%0d PipeEN=%b want %0d 0", StallCount, PipeEN, CNT_SAT);
            errors++;
        end
        checks++;
        MemReady = 1;
        #1;
        if (PipeEN !== 1'b1 || MemTimeout !== 1'b1) begin
            $display("FAIL timeout_release: PipeEN=%b MemTimeout=%b want 1 1", PipeEN, MemTimeout);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        idle();
        #1;
        if (MemTimeout !== 1'b1 || StallCount !== CNT_W'(CNT_SAT)) begin
            $display("FAIL timeout_sticky: MemTimeout=%b StallCount=%0d want 1 %0d", MemTimeout, StallCount, CNT_SAT);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        MEM_MemReq = 1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        #2;
        RESET = 1;
        MEM_MemReq = 0;
        #1;
        if ({PipeEN, MemTimeout} !== 2'b10 || StallCount !== '0) begin
            $display("FAIL reset_mid_wait: PipeEN,MemTimeout got %b want 10, StallCount=%0d want 0",
                     {PipeEN, MemTimeout}, StallCount);
            errors++;
        end
        checks++;
        @(negedge CLOCK);
        RESET = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ID_Valid       = ($urandom_range(0, 7) != 0);
            ID_RSAddr      = 5'($urandom_range(0, 3));
            ID_RTAddr      = 5'($urandom_range(0, 3));
            ID_DstAddr     = 5'($urandom_range(0, 3));
            ID_UsesRT      = ($urandom_range(0, 1) == 1);
            ID_RegWriteEN  = ($urandom_range(0, 3) != 0);
            ID_Mem2RegSEL  = ($urandom_range(0, 2) == 0);
            EX_BranchTaken = ($urandom_range(0, 7) == 0);
            MEM_MemReq     = ($urandom_range(0, 3) == 0);
            MemReady       = ($urandom_range(0, 7) < ((n < 300) ? 4 : 1));
            #1;
            if (obs !== exp_vec) begin
                $display("FAIL random_n%0d: {PC,IFID,Pipe,IFIDFl,IDEXFl,FwdA,FwdB,Cnt,TO} got %b want %b",
                         n, obs, exp_vec);
                errors++;
            end
            checks++;
            @(negedge CLOCK);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward_mem();
        test_zero_reg();
        test_branch_override();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
